input_selector_cfg_ctrl: RTL and testbench
==========================================

Name: input_selector_cfg_ctrl

Overview:
- Configuration sequencer for input_selector_block.
- A host writes per-output selector entries into a shadow bank over a valid/ready port, then requests a commit.
- On commit, the block raises wBusy, holds it for a drain window so the datapath quiesces, then atomically copies the shadow bank onto the flat wSelec bus, pulses done and releases wBusy.
- The input_selector_block never sees a partially updated selector set.

Parameters:
- MAIN_INPUTS, 16, number of main data inputs; main field width MW = $clog2(MAIN_INPUTS) = 4.
- REGS_INPUTS, 64, number of register inputs; regs field width RW = $clog2(REGS_INPUTS) = 6.
- OUTPUTS, 4, number of output buses.
- OUTPUTS_PER_BUS, 4, selectors per bus; N_SEL = OUTPUTS*OUTPUTS_PER_BUS = 16.
- DRAIN_CYCLES, 2, minimum cycles wBusy is high before the copy; legal range is >= 1.
- Derived: SEL_W = RW+MW+1 = 11; IW = $clog2(N_SEL) = 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iCfgValid  in  1  host write request.
- oCfgReady  out  1  block can accept a write this cycle.
- iCfgIndex  in  IW  selector entry index.
- iCfgWord  in  SEL_W  entry value {regs[RW-1:0], main[MW-1:0], origin}.
- iCommit  in  1  commit request, sampled only in IDLE.
- iHold  in  1  datapath not yet idle; freezes the drain counter.
- wBusy  out  1  to input_selector_block; high while reconfiguring.
- wSelec  out  N_SEL*SEL_W  active selectors; entry i occupies [(i+1)*SEL_W-1 : i*SEL_W].
- oCommitDone  out  1  one-cycle pulse when the new selectors are live.
- oDirty  out  1  shadow bank differs from active (written since last commit).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, shadow bank=0, wSelec=0, wBusy=0, oCommitDone=0, oDirty=0, drain counter=0.
  - oCfgReady=1 after reset is released.
- All outputs are registered except oCfgReady, which is decoded from state: oCfgReady = (state==IDLE).
- States: IDLE, DRAIN, COMMIT.
- IDLE:
  - Write accept: iCfgValid && oCfgReady at an edge -> shadow[iCfgIndex] <= iCfgWord and oDirty <= 1.
  - Other shadow entries and wSelec are unchanged by a write.
  - iCommit=1 at an edge -> state DRAIN, wBusy <= 1, cnt <= DRAIN_CYCLES-1.
  - Commit is performed even when oDirty=0; it re-applies the shadow bank.
  - Simultaneous write and iCommit in the same cycle: the write is accepted and is included in the commit.
- DRAIN:
  - oCfgReady=0; iCfgValid is ignored, the shadow is unchanged, and the host must hold the request.
  - iCommit is ignored.
  - At each edge: if iHold=1, cnt holds. Otherwise, if cnt!=0 then cnt--; else wSelec <= shadow (all N_SEL entries in one edge), oDirty <= 0, oCommitDone <= 1, state COMMIT.
  - With iHold=0 throughout, DRAIN lasts exactly DRAIN_CYCLES cycles.
  - Each held cycle extends DRAIN by one cycle; there is no timeout.
- COMMIT (one cycle):
  - wBusy=1, oCommitDone=1, and wSelec already shows the new value.
  - Next edge: wBusy <= 0, oCommitDone <= 0, state IDLE.
- Latency, iCommit sampled at edge E0, no hold:
  - wBusy high from E0+1 to E0+DRAIN_CYCLES+1, i.e. DRAIN_CYCLES+1 cycles.
  - wSelec changes at edge E0+DRAIN_CYCLES, while wBusy is still high.
  - oCommitDone is high for the cycle after E0+DRAIN_CYCLES.
  - The earliest next write is accepted at edge E0+DRAIN_CYCLES+2.
- Reset asserted mid-DRAIN or mid-COMMIT: immediate return to reset values; the pending commit is discarded and the shadow bank is cleared.
- wSelec never changes while wBusy=0.

Test Plan:
1. Reset check: assert reset mid-cycle -> wSelec=0, wBusy=0, oDirty=0, oCommitDone=0 immediately, without waiting for a clock edge; oCfgReady=1 after release.
2. Basic commit:
   - Write idx0=11'h2E0 ({6'h17,4'h0,0}) and idx1=11'h368 ({6'h1b,4'h4,0}); expect oDirty=1.
   - Pulse iCommit -> wBusy high 3 cycles.
   - wSelec[10:0]=11'h2E0 and wSelec[21:11]=11'h368 appear in the third busy cycle; all other entries stay 0.
   - oCommitDone pulses once; oDirty returns to 0.
3. Hold: commit with iHold=1 for the first 4 DRAIN cycles -> wBusy high 7 cycles; wSelec unchanged until the hold drops and the count completes.
4. Write during busy: iCfgValid with idx5=11'h7FF during DRAIN -> oCfgReady=0, shadow[5] stays 0. The held request is accepted in the cycle after wBusy falls; wSelec[65:55] remains 0 until the next commit.
5. Same-cycle write+commit in IDLE: idx15=11'h521 together with iCommit -> after commit completes, wSelec[175:165]=11'h521.
6. Reset mid-DRAIN after writing idx3=11'h260 -> wBusy drops immediately and wSelec stays 0. A following commit with no writes yields wSelec=0 and oCommitDone pulses.

Source files
------------

// File: rtl/input_selector_cfg_ctrl.sv
// Configuration sequencer for input_selector_block: buffers host selector writes in a
// shadow bank and swaps them onto wSelec atomically behind a wBusy drain window.
module input_selector_cfg_ctrl #(
   parameter  int MAIN_INPUTS     = 16,
   parameter  int REGS_INPUTS     = 64,
   parameter  int OUTPUTS         = 4,
   parameter  int OUTPUTS_PER_BUS = 4,
   parameter  int DRAIN_CYCLES    = 2,
   localparam int MW              = $clog2(MAIN_INPUTS),
   localparam int RW              = $clog2(REGS_INPUTS),
   localparam int N_SEL           = OUTPUTS * OUTPUTS_PER_BUS,
   localparam int SEL_W           = RW + MW + 1,
   localparam int IW              = $clog2(N_SEL)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   iCfgValid,
   output logic                   oCfgReady,
   input  logic [IW-1:0]          iCfgIndex,
   input  logic [SEL_W-1:0]       iCfgWord,
   input  logic                   iCommit,
   input  logic                   iHold,
   output logic                   wBusy,
   output logic [N_SEL*SEL_W-1:0] wSelec,
   output logic                   oCommitDone,
   output logic                   oDirty
);

   localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRAIN  = 2'd1,
      COMMIT = 2'd2
   } stateT;

   stateT                   state;
   logic [CW-1:0]           drainCnt;
   logic [N_SEL*SEL_W-1:0]  shadowBank;
   logic                    writeAcc;

   assign oCfgReady = (state == IDLE);
   assign writeAcc  = iCfgValid && oCfgReady;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         drainCnt    <= '0;
         shadowBank  <= '0;
         wSelec      <= '0;
         wBusy       <= 1'b0;
         oCommitDone <= 1'b0;
         oDirty      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A write landing on the same edge as iCommit is part of that commit,
               // since the copy only happens at the end of DRAIN.
               if (writeAcc) begin
                  for (int i = 0; i < N_SEL; i++) begin
                     if (iCfgIndex == IW'(i)) shadowBank[i*SEL_W +: SEL_W] <= iCfgWord;
                  end
                  oDirty <= 1'b1;
               end
               if (iCommit) begin
                  state    <= DRAIN;
                  wBusy    <= 1'b1;
                  drainCnt <= CNT_INIT;
               end
            end
            DRAIN: begin
               if (!iHold) begin
                  if (drainCnt != '0) begin
                     drainCnt <= drainCnt - 1'b1;
                  end else begin
                     wSelec      <= shadowBank;
                     oDirty      <= 1'b0;
                     oCommitDone <= 1'b1;
                     state       <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               wBusy       <= 1'b0;
               oCommitDone <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               wBusy       <= 1'b0;
               oCommitDone <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_input_selector_cfg_ctrl.sv
// Bench for input_selector_cfg_ctrl: directed and random host traffic checked against
// an array model of the shadow/active selector banks and the commit timing rules.
module tb_input_selector_cfg_ctrl;

   localparam int D     = 2;
   localparam int NS    = 16;
   localparam int SW    = 11;
   localparam int IW    = 4;
   localparam int FW    = NS * SW;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          iCfgValid = 1'b0;
   logic          oCfgReady;
   logic [IW-1:0] iCfgIndex = '0;
   logic [SW-1:0] iCfgWord = '0;
   logic          iCommit = 1'b0;
   logic          iHold = 1'b0;
   logic          wBusy;
   logic [FW-1:0] wSelec;
   logic          oCommitDone;
   logic          oDirty;

   logic [SW-1:0] shadowM [NS];
   logic [SW-1:0] activeM [NS];
   bit            dirtyM;

   int total = 0;
   int passed = 0;
   int fails = 0;

   always #5 clk = ~clk;

   input_selector_cfg_ctrl #(.DRAIN_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .iCfgValid(iCfgValid), .oCfgReady(oCfgReady),
      .iCfgIndex(iCfgIndex), .iCfgWord(iCfgWord), .iCommit(iCommit), .iHold(iHold),
      .wBusy(wBusy), .wSelec(wSelec), .oCommitDone(oCommitDone), .oDirty(oDirty)
   );

   function automatic logic [FW-1:0] activeFlat();
      logic [FW-1:0] r;
      for (int i = 0; i < NS; i++) r[i*SW +: SW] = activeM[i];
      return r;
   endfunction

   function automatic logic [FW-1:0] shadowFlat();
      logic [FW-1:0] r;
      for (int i = 0; i < NS; i++) r[i*SW +: SW] = shadowM[i];
      return r;
   endfunction

   task automatic clearModel();
      for (int i = 0; i < NS; i++) begin
         shadowM[i] = '0;
         activeM[i] = '0;
      end
      dirtyM = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      chk({tag, ".ready"}, FW'(oCfgReady), FW'(1));
      chk({tag, ".busy"}, FW'(wBusy), FW'(0));
      chk({tag, ".done"}, FW'(oCommitDone), FW'(0));
      chk({tag, ".dirty"}, FW'(oDirty), FW'(dirtyM));
      chk({tag, ".selec"}, wSelec, activeFlat());
   endtask

   task automatic doWrite(input logic [IW-1:0] idx, input logic [SW-1:0] word);
      bit rdy;
      bit acc;
      acc = 1'b0;
      iCfgValid = 1'b1;
      iCfgIndex = idx;
      iCfgWord  = word;
      for (int n = 0; n < 20 && !acc; n++) begin
         rdy = oCfgReady;
         tick();
         if (rdy) acc = 1'b1;
      end
      iCfgValid = 1'b0;
      if (acc) begin
         shadowM[idx] = word;
         dirtyM = 1'b1;
      end else begin
         chk("write_timeout", FW'(0), FW'(1));
      end
      checkIdle("wr");
   endtask

   // Commit with holdN held DRAIN edges; optional write on the iCommit edge (same*) and
   // optional write request raised during DRAIN that must wait for IDLE (pend*).
   task automatic doCommit(input int holdN,
                           input bit sameWr, input logic [IW-1:0] sIdx, input logic [SW-1:0] sWord,
                           input bit pendWr, input logic [IW-1:0] pIdx, input logic [SW-1:0] pWord);
      logic [FW-1:0] oldSel;
      logic [FW-1:0] newSel;
      bit            oldDirty;
      int            last;
      iCommit = 1'b1;
      if (sameWr) begin
         iCfgValid = 1'b1;
         iCfgIndex = sIdx;
         iCfgWord  = sWord;
      end
      tick();
      iCommit   = 1'b0;
      iCfgValid = 1'b0;
      if (sameWr) begin
         shadowM[sIdx] = sWord;
         dirtyM = 1'b1;
      end
      oldSel   = activeFlat();
      newSel   = shadowFlat();
      oldDirty = dirtyM;
      if (pendWr) begin
         iCfgValid = 1'b1;
         iCfgIndex = pIdx;
         iCfgWord  = pWord;
      end
      last = D + holdN;
      for (int k = 0; k <= last; k++) begin
         if (k > 0) tick();
         chk($sformatf("busy.k%0d", k), FW'(wBusy), FW'(1));
         chk($sformatf("ready.k%0d", k), FW'(oCfgReady), FW'(0));
         chk($sformatf("done.k%0d", k), FW'(oCommitDone), FW'(k == last));
         chk($sformatf("dirty.k%0d", k), FW'(oDirty), FW'((k == last) ? 1'b0 : oldDirty));
         chk($sformatf("selec.k%0d", k), wSelec, (k == last) ? newSel : oldSel);
         iHold = (k < holdN);
      end
      for (int i = 0; i < NS; i++) activeM[i] = shadowM[i];
      dirtyM = 1'b0;
      tick();
      iHold = 1'b0;
      checkIdle("post");
      if (pendWr) begin
         tick();
         iCfgValid = 1'b0;
         shadowM[pIdx] = pWord;
         dirtyM = 1'b1;
         checkIdle("pend");
      end
   endtask

   initial begin
      clearModel();

      // Asynchronous reset takes effect without a clock edge.
      #3 reset = 1'b1;
      #1;
      chk("rst.selec", wSelec, '0);
      chk("rst.busy", FW'(wBusy), FW'(0));
      chk("rst.dirty", FW'(oDirty), FW'(0));
      chk("rst.done", FW'(oCommitDone), FW'(0));
      tick();
      tick();
      reset = 1'b0;
      #1;
      checkIdle("rst_rel");

      // Basic commit.
      doWrite(4'd0, 11'h2E0);
      doWrite(4'd1, 11'h368);
      doCommit(0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("basic.e0", FW'(wSelec[10:0]), FW'(11'h2E0));
      chk("basic.e1", FW'(wSelec[21:11]), FW'(11'h368));
      chk("basic.rest", FW'(wSelec[FW-1:22]), '0);

      // Hold extends DRAIN.
      doWrite(4'd2, 11'h155);
      doCommit(4, 1'b0, '0, '0, 1'b0, '0, '0);

      // Write presented during DRAIN waits until IDLE and misses this commit.
      doCommit(0, 1'b0, '0, '0, 1'b1, 4'd5, 11'h7FF);
      chk("pend.e5", FW'(wSelec[65:55]), '0);
      doCommit(0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("pend.e5.after", FW'(wSelec[65:55]), FW'(11'h7FF));

      // Same-cycle write and commit.
      doCommit(1, 1'b1, 4'd15, 11'h521, 1'b0, '0, '0);
      chk("same.e15", FW'(wSelec[175:165]), FW'(11'h521));

      // Reset during DRAIN discards the commit and clears the shadow.
      doWrite(4'd3, 11'h260);
      iCommit = 1'b1;
      tick();
      iCommit = 1'b0;
      chk("mid.busy_pre", FW'(wBusy), FW'(1));
      #2 reset = 1'b1;
      #1;
      clearModel();
      chk("mid.busy", FW'(wBusy), FW'(0));
      chk("mid.selec", wSelec, '0);
      chk("mid.dirty", FW'(oDirty), FW'(0));
      tick();
      reset = 1'b0;
      #1;
      checkIdle("mid_rel");
      doCommit(0, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("mid.recommit", wSelec, '0);

      // Randomized traffic.
      for (int r = 0; r < 25; r++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) doWrite(IW'($urandom_range(0, NS - 1)), SW'($urandom));
         doCommit($urandom_range(0, 3),
                  1'($urandom_range(0, 1)), IW'($urandom_range(0, NS - 1)), SW'($urandom),
                  1'($urandom_range(0, 1)), IW'($urandom_range(0, NS - 1)), SW'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
